// File: rtl/audio_mix_pkg.sv
// Shared types and helpers for the audio source mixer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: mode_t (output source select), state_t (frame FSM states),
//           sat_s64 (clamp a sign-extended value to a w-bit signed range).
package audio_mix_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_TONE = 2'b01,
    MODE_MIX  = 2'b10,
    MODE_MUTE = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_WRITE   = 2'b10,
    ST_SETTLE  = 2'b11
  } state_t;

  // Clamp a sign-extended value into the range of a w-bit signed number.
  // Callers keep only the low w bits of the result.
  function automatic logic signed [63:0] sat_s64(input logic signed [63:0] v,
                                                 input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/tone_loop_counter.sv
// Tone ROM address generator: loops 0..tone_last, restartable.
// Latency: rom_addr updates one cycle after advance/restart.
// Backpressure: none; advances only when the frame FSM pulses advance.
// Ports: clk, reset (sync, active-high), advance (step once), restart (force 0,
//        wins over advance), tone_last (last loop address), rom_addr (registered).
module tone_loop_counter
  import audio_mix_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              restart,
  input  logic [ADDR_W-1:0] tone_last,
  output logic [ADDR_W-1:0] rom_addr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
    end else if (restart) begin
      rom_addr <= '0;
    end else if (advance) begin
      // ">=" rather than "==" so a loop end lowered below the current
      // address still wraps on the next step instead of running to the top.
      if (rom_addr >= tone_last)
        rom_addr <= '0;
      else
        rom_addr <= rom_addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/audio_source_mixer.sv
// Per CODEC frame: pop one ADC pair, fetch one looped tone sample, push
//   passthrough / tone / mix / silence to the DAC.
// Latency: ready seen in IDLE at cycle n -> registered data + read/write pulse at n+2;
//   4-cycle minimum frame. Backpressure: frame starts only when both FIFOs are
//   ready; once started a frame always completes (ready drops ignored).
// Ports: clk, reset (sync, active-high), mode/vol (sampled at capture),
//   tone_last/restart (tone loop control), read_ready/write_ready + readdata_* +
//   read/write/writedata_* (CODEC FIFOs), rom_addr/rom_q (1-cycle sync ROM).
// Build option: define AUDIO_MIX_SAT_EN to saturate the mix sum; otherwise it wraps.
module audio_source_mixer
  import audio_mix_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [2:0]        vol,
  input  logic [ADDR_W-1:0] tone_last,
  input  logic              restart,
  input  logic              read_ready,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q
);

  state_t state;
  logic   advance;

  logic signed [DATA_W-1:0] tone;
  logic        [DATA_W-1:0] mix_left;
  logic        [DATA_W-1:0] mix_right;
  logic        [DATA_W-1:0] next_left;
  logic        [DATA_W-1:0] next_right;

  // Step the tone loop during the DAC push, so the new address has the
  // SETTLE and IDLE cycles to propagate through the ROM before the next capture.
  assign advance = (state == ST_WRITE);

  tone_loop_counter #(
    .ADDR_W (ADDR_W)
  ) u_tone_loop_counter (
    .clk       (clk),
    .reset     (reset),
    .advance   (advance),
    .restart   (restart),
    .tone_last (tone_last),
    .rom_addr  (rom_addr)
  );

`ifdef AUDIO_MIX_SAT_EN
  // One guard bit keeps the true sum so overflow can be clamped.
  logic signed [DATA_W:0] sum_left;
  logic signed [DATA_W:0] sum_right;

  always_comb begin
    sum_left  = {readdata_left[DATA_W-1], readdata_left} + {tone[DATA_W-1], tone};
    sum_right = {readdata_right[DATA_W-1], readdata_right} + {tone[DATA_W-1], tone};
    mix_left  = DATA_W'(sat_s64(64'(sum_left), DATA_W));
    mix_right = DATA_W'(sat_s64(64'(sum_right), DATA_W));
  end
`else
  // Wrapping mix: the low DATA_W bits of the sum are all that survive.
  always_comb begin
    mix_left  = readdata_left + tone;
    mix_right = readdata_right + tone;
  end
`endif

  always_comb begin
    tone       = $signed(rom_q) >>> vol;
    next_left  = '0;
    next_right = '0;
    case (mode_t'(mode))
      MODE_PASS: begin
        next_left  = readdata_left;
        next_right = readdata_right;
      end
      MODE_TONE: begin
        next_left  = tone;
        next_right = tone;
      end
      MODE_MIX: begin
        next_left  = mix_left;
        next_right = mix_right;
      end
      MODE_MUTE: begin
        next_left  = '0;
        next_right = '0;
      end
      default: begin
        next_left  = '0;
        next_right = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      read            <= 1'b0;
      write           <= 1'b0;
      writedata_left  <= '0;
      writedata_right <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (read_ready && write_ready)
            state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // Data and both FIFO strobes register together so the DAC sees
          // valid data in the same cycle as its push. The ADC pop is issued
          // in every mode so the input FIFO never backs up.
          writedata_left  <= next_left;
          writedata_right <= next_right;
          read            <= 1'b1;
          write           <= 1'b1;
          state           <= ST_WRITE;
        end
        ST_WRITE: begin
          read  <= 1'b0;
          write <= 1'b0;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          state <= ST_IDLE;
        end
        default: begin
          read  <= 1'b0;
          write <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_source_mixer.sv
// Bench for audio_source_mixer: directed and randomized frames against a
// frame-level arithmetic model with a 1-cycle synchronous ROM model.
module tb_audio_source_mixer;

  localparam int DW = 24;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [2:0]    vol;
  logic [AW-1:0] tone_last;
  logic          restart;
  logic          read_ready;
  logic          write_ready;
  logic [DW-1:0] readdata_left;
  logic [DW-1:0] readdata_right;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata_left;
  logic [DW-1:0] writedata_right;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;

  logic [DW-1:0] rom_mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;
  int m_addr   = 0;   // model of the tone loop position
  int m_last   = 3;

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  audio_source_mixer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .mode            (mode),
    .vol             (vol),
    .tone_last       (tone_last),
    .restart         (restart),
    .read_ready      (read_ready),
    .write_ready     (write_ready),
    .readdata_left   (readdata_left),
    .readdata_right  (readdata_right),
    .read            (read),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .rom_addr        (rom_addr),
    .rom_q           (rom_q)
  );

  // Expected DAC word for one channel, from plain integer arithmetic.
  function automatic logic [DW-1:0] model_out(input int md, input int v,
                                              input logic [DW-1:0] rd,
                                              input logic [DW-1:0] rv);
    longint r, t, s, d, rs;
    longint full = longint'(1) << DW;
    longint half = longint'(1) << (DW - 1);
    r  = longint'(rd);
    if (r >= half) r = r - full;
    rs = longint'(rv);
    if (rs >= half) rs = rs - full;
    d = longint'(1) << v;
    // attenuation = floor division by 2**vol
    if (rs >= 0) t = rs / d;
    else         t = -((-rs + d - 1) / d);
    case (md)
      0: s = r;
      1: s = t;
      2: begin
        s = r + t;
`ifdef AUDIO_MIX_SAT_EN
        if (s > half - 1) s = half - 1;
        if (s < -half)    s = -half;
`endif
      end
      default: s = 0;
    endcase
    if (s < 0) s = s + full;
    return DW'(s);
  endfunction

  function automatic int next_addr(input int a, input int last);
    return (a >= last) ? 0 : a + 1;
  endfunction

  task automatic wait_pulse(output bit found, output int cycles);
    found  = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (write === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; restart = 1'b0; read_ready = 1'b0; write_ready = 1'b0;
    mode = 2'b00; vol = 3'd0; tone_last = 16'd3; m_last = 3;
    readdata_left = '0; readdata_right = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    m_addr = 0;
    checks++; if (read !== 1'b0) begin failures++; $display("FAIL reset_read got=%0b exp=0", read); end
    checks++; if (write !== 1'b0) begin failures++; $display("FAIL reset_write got=%0b exp=0", write); end
    checks++; if (writedata_left !== '0) begin failures++; $display("FAIL reset_wdl got=%h exp=0", writedata_left); end
    checks++; if (writedata_right !== '0) begin failures++; $display("FAIL reset_wdr got=%h exp=0", writedata_right); end
    checks++; if (rom_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
  endtask

  task automatic test_passthrough();
    bit found; int cyc;
    logic [DW-1:0] exp_r;
    mode = 2'b00; readdata_left = 24'h123456; readdata_right = DW'($urandom);
    read_ready = 1'b1; write_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      exp_r = readdata_right;
      wait_pulse(found, cyc);
      checks++; if (!found) begin failures++; $display("FAIL pass_timeout frame=%0d", f); end
      checks++; if (writedata_left !== 24'h123456) begin failures++; $display("FAIL pass_left got=%h exp=123456", writedata_left); end
      checks++; if (writedata_right !== exp_r) begin failures++; $display("FAIL pass_right got=%h exp=%h", writedata_right, exp_r); end
      checks++; if (read !== write) begin failures++; $display("FAIL pass_read got=%0b exp=%0b", read, write); end
      if (f == 0) begin
        checks++; if (cyc !== 2) begin failures++; $display("FAIL first_latency got=%0d exp=2", cyc); end
      end else begin
        checks++; if (cyc !== 4) begin failures++; $display("FAIL frame_period got=%0d exp=4", cyc); end
      end
      m_addr = next_addr(m_addr, m_last);
      readdata_right = DW'($urandom);
    end
  endtask

  task automatic test_tone_seq();
    bit found; int cyc;
    int exp_seq [6] = '{1, 2, 3, 4, 1, 2};
    // Restart lands in the advance cycle: restart must win.
    for (int a = 0; a < 4; a++) rom_mem[a] = DW'(a + 1);
    mode = 2'b01; vol = 3'd0; tone_last = 16'd3; m_last = 3;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    m_addr = 0;
    checks++; if (rom_addr !== '0) begin failures++; $display("FAIL restart_vs_advance got=%0d exp=0", rom_addr); end
    for (int f = 0; f < 6; f++) begin
      wait_pulse(found, cyc);
      checks++; if (!found) begin failures++; $display("FAIL tone_timeout frame=%0d", f); end
      checks++; if (writedata_left !== DW'(exp_seq[f])) begin failures++; $display("FAIL tone_left frame=%0d got=%0d exp=%0d", f, writedata_left, exp_seq[f]); end
      checks++; if (writedata_right !== DW'(exp_seq[f])) begin failures++; $display("FAIL tone_right frame=%0d got=%0d exp=%0d", f, writedata_right, exp_seq[f]); end
      m_addr = next_addr(m_addr, m_last);
    end
  endtask

  task automatic test_vol();
    bit found; int cyc;
    for (int a = 0; a < 4; a++) rom_mem[a] = 24'h800000;
    mode = 2'b01; vol = 3'd2;
    for (int f = 0; f < 3; f++) begin
      wait_pulse(found, cyc);
      checks++; if (!found) begin failures++; $display("FAIL vol_timeout frame=%0d", f); end
      checks++; if (writedata_left !== 24'hE00000) begin failures++; $display("FAIL vol_left got=%h exp=e00000", writedata_left); end
      checks++; if (writedata_right !== 24'hE00000) begin failures++; $display("FAIL vol_right got=%h exp=e00000", writedata_right); end
      m_addr = next_addr(m_addr, m_last);
    end
  endtask

  task automatic test_mix();
    bit found; int cyc;
    logic [DW-1:0] exp_pos, exp_neg;
`ifdef AUDIO_MIX_SAT_EN
    exp_pos = 24'h7FFFFF; exp_neg = 24'h800000;
`else
    exp_pos = 24'h800010; exp_neg = 24'h7FFFF5;
`endif
    for (int a = 0; a < 4; a++) rom_mem[a] = 24'h000020;
    mode = 2'b10; vol = 3'd0;
    readdata_left = 24'h7FFFF0; readdata_right = 24'h7FFFF0;
    for (int f = 0; f < 2; f++) begin
      wait_pulse(found, cyc);
      checks++; if (!found) begin failures++; $display("FAIL mix_timeout frame=%0d", f); end
      checks++; if (writedata_left !== exp_pos) begin failures++; $display("FAIL mix_pos_left got=%h exp=%h", writedata_left, exp_pos); end
      checks++; if (writedata_right !== exp_pos) begin failures++; $display("FAIL mix_pos_right got=%h exp=%h", writedata_right, exp_pos); end
      m_addr = next_addr(m_addr, m_last);
    end
    for (int a = 0; a < 4; a++) rom_mem[a] = 24'hFFFFF0;
    readdata_left = 24'h800005; readdata_right = 24'h000005;
    wait_pulse(found, cyc);
    checks++; if (!found) begin failures++; $display("FAIL mix_neg_timeout"); end
    checks++; if (writedata_left !== exp_neg) begin failures++; $display("FAIL mix_neg_left got=%h exp=%h", writedata_left, exp_neg); end
    checks++; if (writedata_right !== 24'hFFFFF5) begin failures++; $display("FAIL mix_small_right got=%h exp=fffff5", writedata_right); end
    m_addr = next_addr(m_addr, m_last);
  endtask

  task automatic test_random();
    bit found; int cyc;
    int md, v;
    logic [DW-1:0] exp_l, exp_r;
    for (int a = 0; a < 16; a++) rom_mem[a] = DW'($urandom);
    for (int f = 0; f < 24; f++) begin
      md = int'($urandom_range(0, 3));
      v  = int'($urandom_range(0, 7));
      mode = 2'(md); vol = 3'(v);
      readdata_left = DW'($urandom); readdata_right = DW'($urandom);
      exp_l = model_out(md, v, readdata_left, rom_mem[m_addr]);
      exp_r = model_out(md, v, readdata_right, rom_mem[m_addr]);
      wait_pulse(found, cyc);
      checks++; if (!found) begin failures++; $display("FAIL rand_timeout frame=%0d", f); end
      checks++; if (writedata_left !== exp_l) begin failures++; $display("FAIL rand_left frame=%0d mode=%0d vol=%0d got=%h exp=%h", f, md, v, writedata_left, exp_l); end
      checks++; if (writedata_right !== exp_r) begin failures++; $display("FAIL rand_right frame=%0d mode=%0d vol=%0d got=%h exp=%h", f, md, v, writedata_right, exp_r); end
      // New loop end applies to the advance happening this cycle.
      m_last = int'($urandom_range(0, 15));
      tone_last = AW'(m_last);
      m_addr = next_addr(m_addr, m_last);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] hold_l, hold_r, exp_l, exp_r;
    int bad = 0;
    write_ready = 1'b0;
    hold_l = writedata_left; hold_r = writedata_right;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (write !== 1'b0 || read !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_pulse got=%0d pulses exp=0", bad); end
    checks++; if (writedata_left !== hold_l) begin failures++; $display("FAIL stall_hold_left got=%h exp=%h", writedata_left, hold_l); end
    checks++; if (writedata_right !== hold_r) begin failures++; $display("FAIL stall_hold_right got=%h exp=%h", writedata_right, hold_r); end
    checks++; if (rom_addr !== AW'(m_addr)) begin failures++; $display("FAIL stall_addr got=%0d exp=%0d", rom_addr, m_addr); end
    mode = 2'b00; readdata_left = DW'($urandom); readdata_right = DW'($urandom);
    exp_l = readdata_left; exp_r = readdata_right;
    write_ready = 1'b1;
    @(negedge clk);
    checks++; if (write !== 1'b0) begin failures++; $display("FAIL stall_early got=%0b exp=0", write); end
    @(negedge clk);
    checks++; if (write !== 1'b1 || read !== 1'b1) begin failures++; $display("FAIL stall_resume got=%0b%0b exp=11", read, write); end
    checks++; if (writedata_left !== exp_l || writedata_right !== exp_r) begin failures++; $display("FAIL stall_data got=%h/%h exp=%h/%h", writedata_left, writedata_right, exp_l, exp_r); end
    m_addr = next_addr(m_addr, m_last);
  endtask

  task automatic test_restart_reset();
    bit found; int cyc;
    int bad = 0;
    tone_last = 16'd7; m_last = 7;
    read_ready = 1'b0; write_ready = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    m_addr = 0;
    read_ready = 1'b1; write_ready = 1'b1;
    mode = 2'b00; readdata_left = 24'hA5A5A5; readdata_right = 24'h5A5A5A;
    for (int f = 0; f < 2; f++) begin
      wait_pulse(found, cyc);
      checks++; if (!found) begin failures++; $display("FAIL rr_timeout frame=%0d", f); end
    end
    read_ready = 1'b0; write_ready = 1'b0;
    @(negedge clk);
    checks++; if (rom_addr !== 16'd2) begin failures++; $display("FAIL addr_two got=%0d exp=2", rom_addr); end
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checks++; if (rom_addr !== '0) begin failures++; $display("FAIL restart_addr got=%0d exp=0", rom_addr); end
    // Start a frame, then reset while it is in CAPTURE.
    read_ready = 1'b1; write_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1; read_ready = 1'b0; write_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (writedata_left !== '0 || writedata_right !== '0) begin failures++; $display("FAIL abort_data got=%h/%h exp=0/0", writedata_left, writedata_right); end
    checks++; if (rom_addr !== '0) begin failures++; $display("FAIL abort_addr got=%0d exp=0", rom_addr); end
    if (read !== 1'b0 || write !== 1'b0) bad++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (read !== 1'b0 || write !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL abort_pulse got=%0d pulses exp=0", bad); end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) rom_mem[a] = '0;
    test_reset();
    test_passthrough();
    test_tone_seq();
    test_vol();
    test_mix();
    test_random();
    test_stall();
    test_restart_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
